mux_pipe_sel: RTL and testbench

Parametrised N:1 data selector for the pipelined CPU datapath, e.g. writeback/forwarding source select. It is the registered, flow-controlled successor to the combinational 8:1 select. It accepts one select+data set per cycle over a valid/ready handshake and presents the chosen word one cycle later. A 2-entry skid buffer keeps throughput at 1/cycle under backpressure with a registered in_ready. Out-of-range selects yield a defined default value and raise a sticky error flag.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/skid_buf2.sv | 72 +++++++
 rtl/mux_pipe_sel.sv | 76 +++++++
 tb/tb_mux_pipe_sel.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath types: skid-buffer occupancy states and the select range check.
package cpu_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   function automatic logic sel_in_range(input int unsigned sel, input int unsigned num_in);
      return sel < num_in;
   endfunction

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer; in_ready depends only on the state register.
//
// state | meaning
// EMPTY | nothing held, out_valid=0
// ONE   | main holds the output word
// FULL  | main and skid both hold words, in_ready=0
module skid_buf2
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   skid_state_t state, state_nxt;
   logic [WIDTH-1:0] main_q, skid_q;
   logic in_fire, out_fire;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (in_fire) state_nxt = ONE;
         ONE: begin
            if (in_fire && !out_fire)      state_nxt = FULL;
            else if (!in_fire && out_fire) state_nxt = EMPTY;
         end
         FULL:    if (out_fire) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      in_ready  = (state != FULL);
      out_valid = (state != EMPTY);
   end

   // Storage is cleared on reset so a flushed skid word can never resurface.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         case (state)
            EMPTY: if (in_fire) main_q <= in_data;
            ONE: begin
               if (in_fire && out_fire) main_q <= in_data;
               else if (in_fire)        skid_q <= in_data;
            end
            FULL:  if (out_fire) main_q <= skid_q;
            default: ;
         endcase
      end
   end

   assign out_data = main_q;

endmodule

// File: rtl/mux_pipe_sel.sv
// Registered N:1 word selector with valid/ready flow control and a sticky range error.
// Optional MUX_PIPE_SEL_TAG_EN adds out_sel, the select that produced the word in main.
module mux_pipe_sel
   import cpu_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter int               NUM_IN      = 6,
   parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
   localparam int              SEL_W       = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
`ifdef MUX_PIPE_SEL_TAG_EN
   output logic [SEL_W-1:0]        out_sel,
`endif
   output logic                    err_flag,
   input  logic                    err_clr
);

`ifdef MUX_PIPE_SEL_TAG_EN
   localparam int BUF_W = WIDTH + SEL_W;
`else
   localparam int BUF_W = WIDTH;
`endif

   logic             in_range;
   logic [WIDTH-1:0] word;
   logic [BUF_W-1:0] buf_in, buf_out;
   logic             in_fire;

   always_comb begin
      in_range = sel_in_range(32'(in_sel), NUM_IN);
      word     = DEFAULT_VAL;
      if (in_range) begin
         for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) word = in_data[k*WIDTH +: WIDTH];
         end
      end
   end

`ifdef MUX_PIPE_SEL_TAG_EN
   assign buf_in   = {in_sel, word};
   assign out_sel  = buf_out[WIDTH +: SEL_W];
`else
   assign buf_in   = word;
`endif
   assign out_data = buf_out[WIDTH-1:0];

   skid_buf2 #(.WIDTH(BUF_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (buf_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (buf_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign in_fire = in_valid & in_ready;

   // A set in the same cycle as a clear takes priority.
   always_ff @(posedge clk) begin
      if (!rst_n)                   err_flag <= 1'b0;
      else if (in_fire && !in_range) err_flag <= 1'b1;
      else if (err_clr)             err_flag <= 1'b0;
   end

endmodule

// File: tb/tb_mux_pipe_sel.sv
// Directed vector bench for mux_pipe_sel (NUM_IN=6, DEFAULT_VAL=32'hDEAD_BEEF).
module tb_mux_pipe_sel;

   localparam int WIDTH  = 32;
   localparam int NUM_IN = 6;
   localparam int SEL_W  = 3;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [SEL_W-1:0]        in_sel;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic                    err_flag;
   logic                    err_clr;
`ifdef MUX_PIPE_SEL_TAG_EN
   logic [SEL_W-1:0]        out_sel;
`endif

   int checks   = 0;
   int failures = 0;

   mux_pipe_sel #(
      .WIDTH       (WIDTH),
      .NUM_IN      (NUM_IN),
      .DEFAULT_VAL (32'hDEAD_BEEF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef MUX_PIPE_SEL_TAG_EN
      .out_sel   (out_sel),
`endif
      .err_flag  (err_flag),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  sel;
      logic        vld;
      logic        ordy;
      logic        clr;
      logic        e_vld;
      logic [31:0] e_data;
      logic        e_rdy;
      logic        e_err;
      logic [2:0]  e_tag;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(input logic [2:0] s, input logic v, input logic o, input logic c,
                               input logic ev, input logic [31:0] ed, input logic er,
                               input logic ee, input logic [2:0] et);
      vec_t r;
      r.sel = s; r.vld = v; r.ordy = o; r.clr = c;
      r.e_vld = ev; r.e_data = ed; r.e_rdy = er; r.e_err = ee; r.e_tag = et;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic drive(input logic rst, input logic [2:0] s, input logic v,
                        input logic o, input logic c);
      @(negedge clk);
      rst_n = rst; in_sel = s; in_valid = v; out_ready = o; err_clr = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < NUM_IN; k++) in_data[k*WIDTH +: WIDTH] = 32'h1000_0000 + 32'(k);
      rst_n = 1'b0; in_sel = 3'd7; in_valid = 1'b1; out_ready = 1'b1; err_clr = 1'b0;

      // Stream with no backpressure, one word per cycle.
      for (int i = 0; i < 6; i++)
         vecs[i] = mk(3'(i), 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0000 + 32'(i), 1'b1, 1'b0, 3'(i));
      vecs[6]  = mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 3'd0);
      // Backpressure fills both entries, then drains in order.
      vecs[7]  = mk(3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0002, 1'b1, 1'b0, 3'd2);
      vecs[8]  = mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0002, 1'b0, 1'b0, 3'd2);
      vecs[9]  = mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0004, 1'b1, 1'b0, 3'd4);
      vecs[10] = mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 3'd0);
      // Out-of-range selects; set beats simultaneous clear.
      vecs[11] = mk(3'd7, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'd7);
      vecs[12] = mk(3'd6, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'd6);
      vecs[13] = mk(3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 3'd0);
      // Stall with a single word held: data must stay stable.
      vecs[14] = mk(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0003, 1'b1, 1'b0, 3'd3);
      vecs[15] = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000_0003, 1'b1, 1'b0, 3'd3);

      // Reset held two cycles with in_valid=1 and an out-of-range select offered.
      drive(1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 3'd7, 1'b1, 1'b1, 1'b0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_err_flag",  32'(err_flag),  32'd0);
      check("rst_out_data",  out_data,       32'h0);
`ifdef MUX_PIPE_SEL_TAG_EN
      check("rst_out_sel",   32'(out_sel),   32'd0);
`endif

      for (int i = 0; i < 16; i++) begin
         drive(1'b1, vecs[i].sel, vecs[i].vld, vecs[i].ordy, vecs[i].clr);
         check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_vld));
         check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_rdy));
         check($sformatf("v%0d_err_flag", i),  32'(err_flag),  32'(vecs[i].e_err));
         if (vecs[i].e_vld) begin
            check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
`ifdef MUX_PIPE_SEL_TAG_EN
            check($sformatf("v%0d_out_sel", i), 32'(out_sel), 32'(vecs[i].e_tag));
`endif
         end
      end

      // Mid-operation reset from FULL: the skid word must never appear.
      drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_out_data", out_data, 32'h1000_0003);
      drive(1'b0, 3'd1, 1'b1, 1'b0, 1'b0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_in_ready",  32'(in_ready),  32'd1);
      check("midrst_out_data",  out_data,       32'h0);
      drive(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
      drive(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
      check("post_rst_out_valid2", 32'(out_valid), 32'd0);

      // Accept after reset still works with single-cycle latency.
      drive(1'b1, 3'd1, 1'b1, 1'b1, 1'b0);
      check("post_rst_accept_valid", 32'(out_valid), 32'd1);
      check("post_rst_accept_data",  out_data,       32'h1000_0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
